// File: rtl/bet_pkg.sv
// Shared definitions for the bet slot bank: FSM state encoding, reserved
// opcode values (functions of the opcode width) and the "no colour" code.
package bet_pkg;

  typedef enum logic [1:0] {
    ST_OPEN   = 2'd0,
    ST_LOCKED = 2'd1,
    ST_DRAIN  = 2'd2
  } bet_state_e;

  localparam logic [2:0] COLOR_NONE = 3'd0;

  // Reserved opcodes sit at the top of the opcode space.
  function automatic logic [31:0] opcode_none(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  function automatic logic [31:0] opcode_spin(input int unsigned w);
    return (32'd1 << w) - 32'd2;
  endfunction

  function automatic logic [31:0] opcode_undo(input int unsigned w);
    return (32'd1 << w) - 32'd3;
  endfunction

endpackage

// File: rtl/bet_strobe_edge.sv
// Rising-edge detector for a level coming from a PS/2-style controller:
// a held level yields a single one-cycle strobe.
module bet_strobe_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic level_i,
  output logic strobe_o
);

  logic level_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level_i;
    end
  end

  assign strobe_o = level_i & ~level_q;

endmodule

// File: rtl/bet_slot_bank.sv
// Bet slot bank: latches colour-tagged bet opcodes, requests a spin, locks
// during it and clears after spin_done. Optional UNDO support: BET_SLOT_UNDO_EN.
//
// Handshake: read_data is a level; only its rising edge is an event. Each
// event yields at most one registered pulse (bet_accept, bet_reject or
// spin_req) one cycle later. spin_done is a one-cycle pulse honoured only
// while LOCKED. state_dbg exposes the FSM state.
module bet_slot_bank
  import bet_pkg::*;
#(
  parameter  int NUM_SLOTS = 12,
  parameter  int OPCODE_W  = 6,
  parameter  int COLOR_W   = 2,
  localparam int SLOT_W    = COLOR_W + OPCODE_W,
  localparam int CNT_W     = $clog2(NUM_SLOTS + 1)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        read_data,
  input  logic [OPCODE_W-1:0]         bet_opcode,
  input  logic [2:0]                  arduino_color,
  input  logic                        spin_done,
  output logic [NUM_SLOTS*SLOT_W-1:0] slots,
  output logic [CNT_W-1:0]            bet_count,
  output logic                        full,
  output logic                        locked,
  output logic                        spin_req,
  output logic                        bet_accept,
  output logic                        bet_reject,
  output bet_state_e                  state_dbg
);

  localparam logic [OPCODE_W-1:0] OP_SPIN = OPCODE_W'(opcode_spin(OPCODE_W));
  localparam logic [OPCODE_W-1:0] OP_NONE = OPCODE_W'(opcode_none(OPCODE_W));
  localparam logic [OPCODE_W-1:0] OP_UNDO = OPCODE_W'(opcode_undo(OPCODE_W));
  localparam logic [CNT_W-1:0]    MAX_CNT = CNT_W'(NUM_SLOTS);

  bet_state_e        state_q, state_d;
  logic [SLOT_W-1:0] slots_q [NUM_SLOTS];
  logic [SLOT_W-1:0] slots_d [NUM_SLOTS];
  logic [CNT_W-1:0]  count_q, count_d;
  logic              accept_q, accept_d;
  logic              reject_q, reject_d;
  logic              spin_q, spin_d;
  logic              strobe;
  logic              is_spin, is_reserved, bet_ok;

  bet_strobe_edge u_edge (
    .clk_i   (clock),
    .rst_i   (reset),
    .level_i (read_data),
    .strobe_o(strobe)
  );

  assign is_spin     = (bet_opcode == OP_SPIN);
  assign is_reserved = is_spin || (bet_opcode == OP_NONE) || (bet_opcode == OP_UNDO);
  assign bet_ok      = !is_reserved && (arduino_color != COLOR_NONE) && (count_q < MAX_CNT);

  always_comb begin
    state_d  = state_q;
    slots_d  = slots_q;
    count_d  = count_q;
    accept_d = 1'b0;
    reject_d = 1'b0;
    spin_d   = 1'b0;
    unique case (state_q)
      ST_OPEN: begin
        if (strobe) begin
          if (is_spin) begin
            if (count_q != '0) begin
              spin_d  = 1'b1;
              state_d = ST_LOCKED;
            end else begin
              reject_d = 1'b1;
            end
`ifdef BET_SLOT_UNDO_EN
          end else if (bet_opcode == OP_UNDO) begin
            if (count_q != '0) begin
              for (int i = 0; i < NUM_SLOTS; i++) begin
                if (CNT_W'(i) == count_q - CNT_W'(1)) slots_d[i] = '0;
              end
              count_d  = count_q - CNT_W'(1);
              accept_d = 1'b1;
            end else begin
              reject_d = 1'b1;
            end
`endif
          end else if (bet_ok) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
              if (CNT_W'(i) == count_q) slots_d[i] = {arduino_color[COLOR_W-1:0], bet_opcode};
            end
            count_d  = count_q + CNT_W'(1);
            accept_d = 1'b1;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      // spin_done has priority; strobes are dropped while locked.
      ST_LOCKED: begin
        if (spin_done) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        for (int i = 0; i < NUM_SLOTS; i++) slots_d[i] = '0;
        count_d = '0;
        state_d = ST_OPEN;
      end
      default: state_d = ST_OPEN;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_OPEN;
      count_q  <= '0;
      accept_q <= 1'b0;
      reject_q <= 1'b0;
      spin_q   <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) slots_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      accept_q <= accept_d;
      reject_q <= reject_d;
      spin_q   <= spin_d;
      for (int i = 0; i < NUM_SLOTS; i++) slots_q[i] <= slots_d[i];
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_flat
    assign slots[g*SLOT_W +: SLOT_W] = slots_q[g];
  end

  assign bet_count  = count_q;
  assign full       = (count_q == MAX_CNT);
  assign locked     = (state_q != ST_OPEN);
  assign spin_req   = spin_q;
  assign bet_accept = accept_q;
  assign bet_reject = reject_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_bet_slot_bank.sv
// Self-checking bench for bet_slot_bank: queue-based reference model checked
// every cycle, directed scenarios with literal expectations, random traffic.
module tb_bet_slot_bank;
  import bet_pkg::*;

  localparam int N = 12;

  logic        clock = 1'b0;
  logic        reset;
  logic        read_data = 1'b0;
  logic [5:0]  bet_opcode = 6'd0;
  logic [2:0]  arduino_color = 3'd0;
  logic        spin_done = 1'b0;
  logic [95:0] slots;
  logic [3:0]  bet_count;
  logic        full, locked, spin_req, bet_accept, bet_reject;
  bet_state_e  state_dbg;

  int tests = 0;
  int fails = 0;

  bet_slot_bank dut (
    .clock        (clock),
    .reset        (reset),
    .read_data    (read_data),
    .bet_opcode   (bet_opcode),
    .arduino_color(arduino_color),
    .spin_done    (spin_done),
    .slots        (slots),
    .bet_count    (bet_count),
    .full         (full),
    .locked       (locked),
    .spin_req     (spin_req),
    .bet_accept   (bet_accept),
    .bet_reject   (bet_reject),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  always #5 clock = ~clock;

  // reference model: accepted bets are a queue; phase 0 open, 1 spinning, 2 clearing
  logic [7:0] exp_q[$];
  int  m_phase = 0;
  bit  m_prev = 0, m_acc = 0, m_rej = 0, m_spin = 0;
`ifdef BET_SLOT_UNDO_EN
  localparam bit UNDO_EN = 1'b1;
`else
  localparam bit UNDO_EN = 1'b0;
`endif

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      exp_q.delete();
      m_phase = 0; m_prev = 0; m_acc = 0; m_rej = 0; m_spin = 0;
    end else begin
      bit ev;
      ev = read_data && !m_prev;
      m_prev = read_data;
      m_acc = 0; m_rej = 0; m_spin = 0;
      if (m_phase == 2) begin
        exp_q.delete();
        m_phase = 0;
      end else if (m_phase == 1) begin
        if (spin_done) m_phase = 2;
      end else if (ev) begin
        if (bet_opcode == 6'd62) begin
          if (exp_q.size() > 0) begin m_spin = 1; m_phase = 1; end
          else m_rej = 1;
        end else if (UNDO_EN && bet_opcode == 6'd61) begin
          if (exp_q.size() > 0) begin void'(exp_q.pop_back()); m_acc = 1; end
          else m_rej = 1;
        end else if (bet_opcode >= 6'd61 || arduino_color == 3'd0 || exp_q.size() >= N) begin
          m_rej = 1;
        end else begin
          exp_q.push_back({arduino_color[1:0], bet_opcode});
          m_acc = 1;
        end
      end
    end
  end

  function automatic logic [95:0] exp_slots();
    logic [95:0] v = '0;
    for (int i = 0; i < exp_q.size(); i++) v[i*8 +: 8] = exp_q[i];
    return v;
  endfunction

  task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: every cycle out of reset
  always @(negedge clock) begin
    if (!reset) begin
      cmp("slots", 128'(slots), 128'(exp_slots()));
      cmp("bet_count", 128'(bet_count), 128'(exp_q.size()));
      cmp("full", 128'(full), 128'(exp_q.size() == N));
      cmp("locked", 128'(locked), 128'(m_phase != 0));
      cmp("bet_accept", 128'(bet_accept), 128'(m_acc));
      cmp("bet_reject", 128'(bet_reject), 128'(m_rej));
      cmp("spin_req", 128'(spin_req), 128'(m_spin));
      cmp("pulse_onehot", 128'($countones({bet_accept, bet_reject, spin_req}) <= 1), 128'(1));
    end
  end

  // driver tasks
  task automatic press(input logic [5:0] op, input logic [2:0] col, input int hold);
    @(negedge clock); #1;
    bet_opcode = op; arduino_color = col; read_data = 1'b1;
    repeat (hold) @(negedge clock);
    #1 read_data = 1'b0;
  endtask

  task automatic pulse_done();
    @(negedge clock); #1 spin_done = 1'b1;
    @(negedge clock); #1 spin_done = 1'b0;
  endtask

  task automatic clear_bank();
    press(6'd62, 3'd1, 1);
    pulse_done();
    repeat (2) @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clock);
    cmp("rst_count", 128'(bet_count), 128'(0));
    cmp("rst_slots", 128'(slots), 128'(0));
    cmp("rst_state", 128'(state_dbg), 128'(ST_OPEN));
    #1 reset = 1'b0;

    // rejects on an empty bank
    press(6'd5, 3'd0, 1);
    cmp("colour0_reject", 128'(bet_reject), 128'(1));
    press(6'b111111, 3'd1, 1);
    cmp("none_reject", 128'(bet_reject), 128'(1));
    press(6'd62, 3'd1, 1);
    cmp("empty_spin_reject", 128'({bet_reject, spin_req}), 128'(2'b10));
    cmp("after_rejects_count", 128'(bet_count), 128'(0));

    // first accepted bet
    press(6'd5, 3'b010, 1);
    cmp("first_accept", 128'(bet_accept), 128'(1));
    cmp("slot0", 128'(slots[7:0]), 128'(8'b10_000101));
    cmp("count1", 128'(bet_count), 128'(1));
    @(negedge clock);
    cmp("accept_one_cycle", 128'(bet_accept), 128'(0));

    // held key: one event only
    press(6'd7, 3'd1, 10);
    cmp("held_count", 128'(bet_count), 128'(2));
    cmp("slot1", 128'(slots[15:8]), 128'(8'b01_000111));

    // third bet, spin, lock, drain
    press(6'd9, 3'd3, 1);
    press(6'd62, 3'd2, 1);
    cmp("spin_req", 128'(spin_req), 128'(1));
    cmp("locked", 128'(locked), 128'(1));
    press(6'd10, 3'd1, 1);
    cmp("lock_ignore", 128'({bet_accept, bet_reject, bet_count}), 128'({2'b00, 4'd3}));
    pulse_done();
    cmp("drain_locked", 128'(locked), 128'(1));
    cmp("drain_state", 128'(state_dbg), 128'(ST_DRAIN));
    @(negedge clock);
    cmp("cleared", 128'({slots, bet_count, locked}), 128'(0));

    // fill to capacity
    for (int i = 0; i < 13; i++) begin
      press(6'(i), 3'((i % 3) + 1), 1);
      if (i == 11) cmp("full_at_12", 128'({full, bet_count}), 128'({1'b1, 4'd12}));
    end
    cmp("overflow_reject", 128'({bet_reject, bet_count}), 128'({1'b1, 4'd12}));
    cmp("slot11_kept", 128'(slots[95:88]), 128'(8'b11_001011));
    clear_bank();

    // undo
    press(6'd20, 3'd1, 1);
    press(6'd21, 3'd2, 1);
    press(6'd61, 3'd1, 1);
`ifdef BET_SLOT_UNDO_EN
    cmp("undo_count", 128'({bet_accept, bet_count}), 128'({1'b1, 4'd1}));
    cmp("undo_slot1", 128'(slots[15:8]), 128'(0));
`else
    cmp("undo_reserved", 128'({bet_reject, bet_count}), 128'({1'b1, 4'd2}));
`endif
    clear_bank();

    // random traffic against the model
    for (int k = 0; k < 800; k++) begin
      int r;
      @(negedge clock); #1;
      read_data = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      bet_opcode = (r == 0) ? 6'd62 : (r == 1) ? 6'd61 : (r == 2) ? 6'd63 : 6'($urandom_range(0, 60));
      arduino_color = ($urandom_range(0, 5) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      spin_done = ($urandom_range(0, 5) == 0);
    end
    @(negedge clock); #1;
    read_data = 1'b0; spin_done = 1'b0;
    repeat (3) @(negedge clock);
    clear_bank();

    // reset in the middle of a spin
    press(6'd1, 3'd1, 1);
    press(6'd2, 3'd2, 1);
    press(6'd3, 3'd3, 1);
    press(6'd62, 3'd1, 1);
    @(negedge clock);
    cmp("pre_reset_locked", 128'(locked), 128'(1));
    #2 reset = 1'b1;
    #1;
    cmp("async_reset", 128'({slots, bet_count, full, locked, spin_req, bet_accept, bet_reject}), 128'(0));
    cmp("async_reset_state", 128'(state_dbg), 128'(ST_OPEN));
    @(negedge clock); #1 reset = 1'b0;
    repeat (3) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
